i2s_frame_gen: RTL and testbench

Master-side frame generator that sits directly upstream of the I2S serializer. It derives the bit clock and word-select from the single system clock. It accepts stereo sample pairs over a valid/ready handshake and presents per-frame-stable left/right parallel words for the serializer to shift out. It also flags underruns when no sample pair is available at a frame boundary.

---
 rtl/i2s_frame_gen.sv | 135 +++++++++++++
 tb/tb_i2s_frame_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_gen.sv
// I2S master frame generator: derives bck/lrck from i_clk and presents per-frame-stable L/R words.
// Optional: define I2S_FRAME_GEN_HOLD_LAST_EN to repeat the last pair on underrun instead of silence.
module i2s_frame_gen #(
  parameter int unsigned WORD_SIZE  = 24,
  parameter int unsigned BCK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_l_data,
  input  logic [WORD_SIZE-1:0] i_r_data,
  output logic                 o_ready,
  output logic                 o_bck,
  output logic                 o_lrck,
  output logic [WORD_SIZE-1:0] o_l_din,
  output logic [WORD_SIZE-1:0] o_r_din,
  output logic                 o_frame_start,
  output logic                 o_underrun
);

  localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * FRAME_BITS);

  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 bck_q, bck_d;
  logic                 lrck_q, lrck_d;
  logic                 fs_q, fs_d;
  logic                 ur_q, ur_d;
  logic [WORD_SIZE-1:0] out_l_q, out_l_d;
  logic [WORD_SIZE-1:0] out_r_q, out_r_d;
  logic [WORD_SIZE-1:0] hold_l_q, hold_l_d;
  logic [WORD_SIZE-1:0] hold_r_q, hold_r_d;
  logic                 hold_full_q, hold_full_d;

  logic div_wrap;
  logic bck_fall;
  logic frame_start;
  logic xfer;

  assign o_ready = !hold_full_q && !i_rst;

  // Next-state: clock division, frame position and sample routing
  always_comb begin
    div_d       = div_q;
    bit_d       = bit_q;
    bck_d       = bck_q;
    lrck_d      = lrck_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;

    div_wrap    = (div_q == DIV_W'(BCK_DIV - 1));
    bck_fall    = div_wrap && bck_q;
    frame_start = bck_fall && (bit_q == BIT_W'(2 * FRAME_BITS - 1));
    xfer        = i_valid && o_ready;

    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
    if (div_wrap) begin
      bck_d = ~bck_q;
    end

    if (bck_fall) begin
      bit_d  = frame_start ? '0 : bit_q + BIT_W'(1);
      lrck_d = (bit_d >= BIT_W'(FRAME_BITS));
    end

    // A frame start drains hold, else bypasses a same-cycle transfer, else underruns
    if (frame_start) begin
      fs_d = 1'b1;
      if (hold_full_q) begin
        out_l_d     = hold_l_q;
        out_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else if (xfer) begin
        out_l_d = i_l_data;
        out_r_d = i_r_data;
      end else begin
        ur_d = 1'b1;
`ifdef I2S_FRAME_GEN_HOLD_LAST_EN
        out_l_d = out_l_q;
        out_r_d = out_r_q;
`else
        out_l_d = '0;
        out_r_d = '0;
`endif
      end
    end else if (xfer) begin
      hold_l_d    = i_l_data;
      hold_r_d    = i_r_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q       <= '0;
      bit_q       <= '0;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      bck_q       <= bck_d;
      lrck_q      <= lrck_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign o_bck         = bck_q;
  assign o_lrck        = lrck_q;
  assign o_frame_start = fs_q;
  assign o_underrun    = ur_q;
  assign o_l_din       = out_l_q;
  assign o_r_din       = out_r_q;

endmodule

// File: tb/tb_i2s_frame_gen.sv
// Self-checking bench for i2s_frame_gen against a cycle-count based reference model.
module tb_i2s_frame_gen;

  localparam int WS        = 24;
  localparam int BD        = 4;
  localparam int FB        = 32;
  localparam int FRAME_CYC = 4 * BD * FB;
  localparam int HALF_CYC  = 2 * BD * FB;
`ifdef I2S_FRAME_GEN_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [WS-1:0] l_in = '0;
  logic [WS-1:0] r_in = '0;
  logic          o_ready, o_bck, o_lrck, o_frame_start, o_underrun;
  logic [WS-1:0] o_l_din, o_r_din;

  i2s_frame_gen #(.WORD_SIZE(WS), .BCK_DIV(BD), .FRAME_BITS(FB)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_l_data(l_in), .i_r_data(r_in),
    .o_ready(o_ready), .o_bck(o_bck), .o_lrck(o_lrck), .o_l_din(o_l_din),
    .o_r_din(o_r_din), .o_frame_start(o_frame_start), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edge count since reset release plus a one-entry holding slot
  int            n = 0;
  logic          m_full = 1'b0;
  logic [WS-1:0] m_hl = '0, m_hr = '0, m_ol = '0, m_or = '0;
  logic          m_fs = 1'b0, m_ur = 1'b0, m_bck = 1'b0, m_lrck = 1'b0;
  logic          last_xfer = 1'b0;

  task automatic tick();
    logic          xfer;
    logic [WS-1:0] li, ri;
    xfer = valid && !m_full && !rst;
    li   = l_in;
    ri   = r_in;
    @(posedge clk);
    if (rst) begin
      n = 0; m_full = 1'b0; m_ol = '0; m_or = '0;
      m_fs = 1'b0; m_ur = 1'b0; m_bck = 1'b0; m_lrck = 1'b0;
      xfer = 1'b0;
    end else begin
      n++;
      m_fs = ((n % FRAME_CYC) == 0);
      m_ur = 1'b0;
      if (m_fs) begin
        if (m_full) begin
          m_ol = m_hl; m_or = m_hr; m_full = 1'b0;
        end else if (xfer) begin
          m_ol = li; m_or = ri;
        end else begin
          m_ur = 1'b1;
          if (!HOLD_LAST) begin m_ol = '0; m_or = '0; end
        end
      end else if (xfer) begin
        m_hl = li; m_hr = ri; m_full = 1'b1;
      end
      m_bck  = ((n / BD) % 2) == 1;
      m_lrck = ((n / HALF_CYC) % 2) == 1;
    end
    last_xfer = xfer;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    tick(); tick();
    checks++;
    if ({o_bck, o_lrck, o_frame_start, o_underrun} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 0000", {o_bck, o_lrck, o_frame_start, o_underrun});
    end
    checks++;
    if ({o_l_din, o_r_din} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0/0", o_l_din, o_r_din);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", o_ready);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_clock_shape();
    do_reset();
    while (n < 2 * FRAME_CYC + 8) begin
      tick();
      checks++;
      if ({o_bck, o_lrck, o_frame_start} !== {m_bck, m_lrck, m_fs}) begin
        errors++; $display("FAIL clk_shape n=%0d got bck/lrck/fs %b want %b", n,
                           {o_bck, o_lrck, o_frame_start}, {m_bck, m_lrck, m_fs});
      end
      if ((n >= 4 && n <= 7) || (n >= 8 && n <= 11)) begin
        checks++;
        if (o_bck !== (n <= 7)) begin
          errors++; $display("FAIL bck_edge n=%0d got %b want %b", n, o_bck, (n <= 7));
        end
      end
      if (n == 255 || n == 256) begin
        checks++;
        if (o_lrck !== (n == 256)) begin
          errors++; $display("FAIL lrck_rise n=%0d got %b want %b", n, o_lrck, (n == 256));
        end
      end
      checks++;
      if (o_frame_start !== (n == 512 || n == 1024)) begin
        errors++; $display("FAIL fs_pulse n=%0d got %b", n, o_frame_start);
      end
    end
  endtask

  task automatic test_normal_stream();
    logic [WS-1:0] l2, r2;
    l2 = 24'($urandom); r2 = 24'($urandom);
    do_reset();
    while (n < 2 * FRAME_CYC + 2) begin
      if (n == 9) begin valid = 1'b1; l_in = 24'h123456; r_in = 24'hABCDEF; end
      tick();
      if (last_xfer) begin l_in = l2; r_in = r2; end
      if (n >= 10 && n < FRAME_CYC) begin
        checks++;
        if (o_ready !== 1'b0) begin
          errors++; $display("FAIL ns_ready n=%0d got %b want 0", n, o_ready);
        end
      end
      if (n == FRAME_CYC || n == 2 * FRAME_CYC - 1) begin
        checks++;
        if ({o_l_din, o_r_din} !== {24'h123456, 24'hABCDEF}) begin
          errors++; $display("FAIL ns_data n=%0d got %h/%h want 123456/abcdef", n, o_l_din, o_r_din);
        end
      end
      if (n == 2 * FRAME_CYC) begin
        checks++;
        if ({o_l_din, o_r_din} !== {l2, r2}) begin
          errors++; $display("FAIL ns_data2 got %h/%h want %h/%h", o_l_din, o_r_din, l2, r2);
        end
      end
      checks++;
      if (o_underrun !== 1'b0) begin
        errors++; $display("FAIL ns_underrun n=%0d got 1 want 0", n);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_underrun();
    do_reset();
    valid = 1'b1; l_in = 24'h000001; r_in = 24'h000002;
    while (n < 2 * FRAME_CYC + 1) begin
      tick();
      if (last_xfer) valid = 1'b0;
      if (n == FRAME_CYC) begin
        checks++;
        if ({o_underrun, o_l_din, o_r_din} !== {1'b0, 24'h000001, 24'h000002}) begin
          errors++; $display("FAIL ur_first got ur=%b %h/%h want 0 000001/000002", o_underrun, o_l_din, o_r_din);
        end
      end
      if (n == 2 * FRAME_CYC) begin
        checks++;
        if ({o_underrun, o_l_din, o_r_din} !== {1'b1, (HOLD_LAST ? 48'h000001000002 : 48'h0)}) begin
          errors++; $display("FAIL ur_pulse got ur=%b %h/%h want 1 hold_last=%b", o_underrun, o_l_din, o_r_din, HOLD_LAST);
        end
      end
      if (n == 2 * FRAME_CYC - 1 || n == 2 * FRAME_CYC + 1) begin
        checks++;
        if (o_underrun !== 1'b0) begin
          errors++; $display("FAIL ur_width n=%0d got 1 want 0", n);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [WS-1:0] lb, rb;
    lb = 24'($urandom); rb = 24'($urandom);
    do_reset();
    while (n < FRAME_CYC + 1) begin
      if (n == FRAME_CYC - 1) begin valid = 1'b1; l_in = lb; r_in = rb; end
      tick();
      if (n == FRAME_CYC) begin
        valid = 1'b0;
        checks++;
        if ({o_frame_start, o_underrun, o_l_din, o_r_din} !== {2'b10, lb, rb}) begin
          errors++; $display("FAIL bypass got fs=%b ur=%b %h/%h want 1 0 %h/%h",
                             o_frame_start, o_underrun, o_l_din, o_r_din, lb, rb);
        end
      end
      if (n == FRAME_CYC || n == FRAME_CYC + 1) begin
        checks++;
        if (o_ready !== 1'b1) begin
          errors++; $display("FAIL bypass_ready n=%0d got %b want 1", n, o_ready);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 1'b1; l_in = 24'h55AA55; r_in = 24'hAA55AA;
    while (n < 299) begin
      tick();
      if (last_xfer) valid = 1'b0;
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({o_bck, o_lrck, o_frame_start, o_underrun, o_ready, o_l_din, o_r_din} !== '0) begin
      errors++; $display("FAIL rst_mid got bck=%b lrck=%b rdy=%b %h/%h want all 0",
                         o_bck, o_lrck, o_ready, o_l_din, o_r_din);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready got %b want 1", o_ready);
    end
    while (n < FRAME_CYC) begin
      tick();
      if (n == BD - 1 || n == BD) begin
        checks++;
        if (o_bck !== (n == BD)) begin
          errors++; $display("FAIL rst_mid_bck n=%0d got %b want %b", n, o_bck, (n == BD));
        end
      end
    end
    checks++;
    if ({o_underrun, o_l_din, o_r_din} !== {1'b1, 48'h0}) begin
      errors++; $display("FAIL rst_mid_hold got ur=%b %h/%h want 1 0/0", o_underrun, o_l_din, o_r_din);
    end
  endtask

  task automatic test_serializer();
    logic          prev_bck, tx_lrck, rx_lrck, sd;
    logic [WS-1:0] sr, rx, exp;
    int            rcnt, words;
    prev_bck = 1'b0; tx_lrck = 1'b0; rx_lrck = 1'b0; sd = 1'b0;
    sr = '0; rx = '0; rcnt = 0; words = 0;
    do_reset();
    valid = 1'b1; l_in = 24'h800001; r_in = 24'h7FFFFE;
    while (n < 3 * FRAME_CYC + 300) begin
      tick();
      // Transmitter: load on the lrck edge, shift MSB-first on following bck falls
      if (prev_bck && !o_bck) begin
        if (o_lrck != tx_lrck) begin
          sr = o_lrck ? o_r_din : o_l_din;
          tx_lrck = o_lrck;
        end else begin
          sd = sr[WS-1];
          sr = sr << 1;
        end
      end
      if (!prev_bck && o_bck) begin
        if (o_lrck != rx_lrck) begin rcnt = 0; rx_lrck = o_lrck; end
        else rcnt++;
        if (rcnt >= 1 && rcnt <= WS) rx = {rx[WS-2:0], sd};
        if (rcnt == WS && n > FRAME_CYC) begin
          exp = o_lrck ? 24'h7FFFFE : 24'h800001;
          words++;
          checks++;
          if (rx !== exp) begin
            errors++; $display("FAIL serial n=%0d lrck=%b got %h want %h", n, o_lrck, rx, exp);
          end
        end
      end
      prev_bck = o_bck;
    end
    valid = 1'b0;
    checks++;
    if (words < 4) begin
      errors++; $display("FAIL serial_count got %0d words want >=4", words);
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    while (n < 8 * FRAME_CYC + 4) begin
      case ((n / FRAME_CYC) % 3)
        0:       p = 0;
        1:       p = 1;
        default: p = 40;
      endcase
      if (!valid && $urandom_range(0, 99) < p) begin
        valid = 1'b1; l_in = 24'($urandom); r_in = 24'($urandom);
      end
      tick();
      if (last_xfer) valid = 1'b0;
      checks++;
      if ({o_bck, o_lrck, o_frame_start, o_underrun, o_ready, o_l_din, o_r_din} !==
          {m_bck, m_lrck, m_fs, m_ur, !m_full, m_ol, m_or}) begin
        errors++; $display("FAIL random n=%0d got %b%b%b%b%b %h/%h want %b%b%b%b%b %h/%h", n,
                           o_bck, o_lrck, o_frame_start, o_underrun, o_ready, o_l_din, o_r_din,
                           m_bck, m_lrck, m_fs, m_ur, !m_full, m_ol, m_or);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clock_shape();
    test_normal_stream();
    test_underrun();
    test_bypass();
    test_reset_mid();
    test_serializer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
